// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared types and constants for the 24-bit execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int DW = 24;
    localparam int RW = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    // NZCV packing: N is the MSB
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    // The younger (MEM) producer shadows the older (WB) one.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_if
// Description : ID/EX inputs, writeback bus and EX/MEM outputs of execute_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_if #(
    parameter int DW = exec_pkg::DW,
    parameter int RW = exec_pkg::RW
);
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [DW-1:0] ExtImm;
    logic [RW-1:0] WA3E;
    logic          regWriteE;
    logic          aluSrcE;
    logic          PCSrcE;
    logic          memToRegE;
    logic          memWriteE;
    logic [1:0]    aluControlE;
    logic          validE;
    logic          stallM;
    logic          flushM;
    logic [RW-1:0] RA1E;
    logic [RW-1:0] RA2E;
    logic [DW-1:0] ResultW;
    logic [RW-1:0] WA3W;
    logic          regWriteW;

    logic [DW-1:0] ALUResultM;
    logic [DW-1:0] WriteDataM;
    logic [RW-1:0] WA3M;
    logic          regWriteM;
    logic          PCSrcM;
    logic          memToRegM;
    logic          memWriteM;
    logic          validM;
    logic [3:0]    FlagsM;

    modport master (
        output SrcA, SrcB, ExtImm, WA3E, regWriteE, aluSrcE, PCSrcE, memToRegE,
               memWriteE, aluControlE, validE, stallM, flushM, RA1E, RA2E,
               ResultW, WA3W, regWriteW,
        input  ALUResultM, WriteDataM, WA3M, regWriteM, PCSrcM, memToRegM,
               memWriteM, validM, FlagsM
    );

    modport slave (
        input  SrcA, SrcB, ExtImm, WA3E, regWriteE, aluSrcE, PCSrcE, memToRegE,
               memWriteE, aluControlE, validE, stallM, flushM, RA1E, RA2E,
               ResultW, WA3W, regWriteW,
        output ALUResultM, WriteDataM, WA3M, regWriteM, PCSrcM, memToRegM,
               memWriteM, validM, FlagsM
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage_alu24.sv
`default_nettype none
// ============================================================================
// Module      : alu24
// Description : Combinational ADD/SUB/AND/OR unit with NZCV flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu24 #(
    parameter int DW = exec_pkg::DW
) (
    input  wire logic [DW-1:0]     a,
    input  wire logic [DW-1:0]     b,
    input  exec_pkg::alu_op_t      op,
    output logic      [DW-1:0]     y,
    output logic      [3:0]        nzcv
);
    import exec_pkg::*;

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;
    logic        w_c;
    logic        w_v;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y   = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = w_sum[DW-1:0];
                w_c = w_sum[DW];
                w_v = (a[DW-1] == b[DW-1]) && (w_sum[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                y   = w_diff[DW-1:0];
                // Borrow out of the extended subtract is the inverse of carry
                w_c = ~w_diff[DW];
                w_v = (a[DW-1] != b[DW-1]) && (w_diff[DW-1] != a[DW-1]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

    always_comb begin
        nzcv         = 4'b0000;
        nzcv[FLAG_N] = y[DW-1];
        nzcv[FLAG_Z] = (y == '0);
        nzcv[FLAG_C] = w_c;
        nzcv[FLAG_V] = w_v;
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : ALU execute plus EX/MEM register with stall/flush/valid gating.
//               Optional MEM/WB operand forwarding when EXEC_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int DW = exec_pkg::DW,
    parameter int RW = exec_pkg::RW
) (
    input  wire logic clk,
    input  wire logic reset,
    exec_if.slave     bus
);
    import exec_pkg::*;

    localparam logic [RW-1:0] C_NO_FWD_REG = {RW{1'b1}};

    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_src_b;
    logic [DW-1:0] w_op_b;
    logic [DW-1:0] w_alu_y;
    logic [3:0]    w_alu_nzcv;

    logic [DW-1:0] r_alu_result_q;
    logic [DW-1:0] r_write_data_q;
    logic [RW-1:0] r_wa3_q;
    logic          r_reg_write_q;
    logic          r_pc_src_q;
    logic          r_mem_to_reg_q;
    logic          r_mem_write_q;
    logic          r_valid_q;
    logic [3:0]    r_flags_q;

`ifdef EXEC_FWD_EN
    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;

    always_comb begin
        w_sel_a = fwd_pick(
            r_valid_q && r_reg_write_q && (r_wa3_q == bus.RA1E) && (bus.RA1E != C_NO_FWD_REG),
            bus.regWriteW && (bus.WA3W == bus.RA1E) && (bus.RA1E != C_NO_FWD_REG));
        w_sel_b = fwd_pick(
            r_valid_q && r_reg_write_q && (r_wa3_q == bus.RA2E) && (bus.RA2E != C_NO_FWD_REG),
            bus.regWriteW && (bus.WA3W == bus.RA2E) && (bus.RA2E != C_NO_FWD_REG));

        case (w_sel_a)
            FWD_MEM: w_op_a = r_alu_result_q;
            FWD_WB:  w_op_a = bus.ResultW;
            default: w_op_a = bus.SrcA;
        endcase
        case (w_sel_b)
            FWD_MEM: w_src_b = r_alu_result_q;
            FWD_WB:  w_src_b = bus.ResultW;
            default: w_src_b = bus.SrcB;
        endcase
    end
`else
    logic w_unused_fwd;

    assign w_op_a       = bus.SrcA;
    assign w_src_b      = bus.SrcB;
    assign w_unused_fwd = ^{bus.RA1E, bus.RA2E, bus.ResultW, bus.WA3W,
                            bus.regWriteW, C_NO_FWD_REG};
`endif

    // Store data always comes from the register path, never the immediate
    assign w_op_b = bus.aluSrcE ? bus.ExtImm : w_src_b;

    alu24 #(.DW(DW)) u_alu (
        .a    (w_op_a),
        .b    (w_op_b),
        .op   (alu_op_t'(bus.aluControlE)),
        .y    (w_alu_y),
        .nzcv (w_alu_nzcv)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.flushM) begin
            r_alu_result_q <= '0;
            r_write_data_q <= '0;
            r_wa3_q        <= '0;
            r_reg_write_q  <= 1'b0;
            r_pc_src_q     <= 1'b0;
            r_mem_to_reg_q <= 1'b0;
            r_mem_write_q  <= 1'b0;
            r_valid_q      <= 1'b0;
            r_flags_q      <= 4'b0000;
        end else if (!bus.stallM) begin
            r_alu_result_q <= w_alu_y;
            r_write_data_q <= w_src_b;
            r_wa3_q        <= bus.WA3E;
            // Bubbles may carry data but must never have architectural side effects
            r_reg_write_q  <= bus.regWriteE & bus.validE;
            r_pc_src_q     <= bus.PCSrcE    & bus.validE;
            r_mem_write_q  <= bus.memWriteE & bus.validE;
            r_mem_to_reg_q <= bus.memToRegE;
            r_valid_q      <= bus.validE;
            r_flags_q      <= w_alu_nzcv;
        end
    end

    assign bus.ALUResultM = r_alu_result_q;
    assign bus.WriteDataM = r_write_data_q;
    assign bus.WA3M       = r_wa3_q;
    assign bus.regWriteM  = r_reg_write_q;
    assign bus.PCSrcM     = r_pc_src_q;
    assign bus.memToRegM  = r_mem_to_reg_q;
    assign bus.memWriteM  = r_mem_write_q;
    assign bus.validM     = r_valid_q;
    assign bus.FlagsM     = r_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Scoreboard bench for execute_stage; forwarding vectors are
//               included when EXEC_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    typedef struct {
        string       name;
        logic [23:0] alu;
        logic [23:0] wd;
        logic [3:0]  wa;
        logic [4:0]  ctl;   // {regWrite, PCSrc, memToReg, memWrite, valid}
        logic [3:0]  fl;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    exec_if #(.DW(24), .RW(4)) bus ();

    execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the EX/MEM outputs one delta after each edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act_ctl;
            e       = sb.pop_front();
            act_ctl = {bus.regWriteM, bus.PCSrcM, bus.memToRegM, bus.memWriteM, bus.validM};
            n_tests++;
            if (bus.ALUResultM !== e.alu || bus.WriteDataM !== e.wd || bus.WA3M !== e.wa ||
                act_ctl !== e.ctl || bus.FlagsM !== e.fl) begin
                n_fail++;
                $display("FAIL %s: got alu=%h wd=%h wa=%h ctl=%b nzcv=%b, want alu=%h wd=%h wa=%h ctl=%b nzcv=%b",
                         e.name, bus.ALUResultM, bus.WriteDataM, bus.WA3M, act_ctl, bus.FlagsM,
                         e.alu, e.wd, e.wa, e.ctl, e.fl);
            end
        end
    end

    task automatic set_op(input logic [23:0] a, input logic [23:0] b, input logic [23:0] imm,
                          input logic asrc, input logic [1:0] op, input logic [3:0] wa,
                          input logic rw, input logic pcs, input logic m2r, input logic mw,
                          input logic v);
        bus.SrcA        = a;
        bus.SrcB        = b;
        bus.ExtImm      = imm;
        bus.aluSrcE     = asrc;
        bus.aluControlE = op;
        bus.WA3E        = wa;
        bus.regWriteE   = rw;
        bus.PCSrcE      = pcs;
        bus.memToRegE   = m2r;
        bus.memWriteE   = mw;
        bus.validE      = v;
    endtask

    // Current inputs are captured at the next edge; queue what that edge must produce.
    task automatic step(input string nm, input logic [23:0] alu, input logic [23:0] wd,
                        input logic [3:0] wa, input logic [4:0] ctl, input logic [3:0] fl);
        exp_t e;
        e = '{name: nm, alu: alu, wd: wd, wa: wa, ctl: ctl, fl: fl};
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.stallM    = 1'b0;
        bus.flushM    = 1'b0;
        bus.RA1E      = 4'hF;
        bus.RA2E      = 4'hF;
        bus.ResultW   = 24'h0;
        bus.WA3W      = 4'h0;
        bus.regWriteW = 1'b0;
        set_op(24'h111111, 24'h222222, 24'h0, 1'b0, 2'b00, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);

        step("reset0", 24'h0, 24'h0, 4'h0, 5'b00000, 4'b0000);
        step("reset1", 24'h0, 24'h0, 4'h0, 5'b00000, 4'b0000);
        reset = 1'b0;
        step("first_load", 24'h333333, 24'h222222, 4'h3, 5'b11111, 4'b0000);

        set_op(24'h7FFFFF, 24'h000001, 24'h0, 1'b0, 2'b00, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("add_ovf", 24'h800000, 24'h000001, 4'h1, 5'b10001, 4'b1001);
        set_op(24'h000005, 24'h000005, 24'h0, 1'b0, 2'b01, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("sub_zero", 24'h000000, 24'h000005, 4'h2, 5'b10001, 4'b0110);
        set_op(24'h000000, 24'h000001, 24'h0, 1'b0, 2'b01, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("sub_borrow", 24'hFFFFFF, 24'h000001, 4'h2, 5'b10001, 4'b1000);
        set_op(24'h800000, 24'h000001, 24'h0, 1'b0, 2'b01, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("sub_ovf", 24'h7FFFFF, 24'h000001, 4'h4, 5'b10001, 4'b0011);
        set_op(24'h000001, 24'h123456, 24'h000010, 1'b1, 2'b00, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("imm_store", 24'h000011, 24'h123456, 4'h9, 5'b00011, 4'b0000);
        set_op(24'hF0F0F0, 24'hFF00FF, 24'h0, 1'b0, 2'b10, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("and", 24'hF000F0, 24'hFF00FF, 4'h5, 5'b10101, 4'b1000);
        set_op(24'h000000, 24'h000000, 24'h0, 1'b0, 2'b11, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("or_zero", 24'h000000, 24'h000000, 4'h8, 5'b01001, 4'b0100);
        set_op(24'hFFFFFF, 24'h000001, 24'h0, 1'b0, 2'b00, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("add_carry", 24'h000000, 24'h000001, 4'h6, 5'b10001, 4'b0110);

        set_op(24'h000010, 24'h000020, 24'h0, 1'b0, 2'b00, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("stall_load", 24'h000030, 24'h000020, 4'h7, 5'b10001, 4'b0000);
        bus.stallM = 1'b1;
        set_op(24'hAAAAAA, 24'h555555, 24'h0, 1'b0, 2'b11, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_hold%0d", i), 24'h000030, 24'h000020, 4'h7, 5'b10001, 4'b0000);
        bus.flushM = 1'b1;
        step("flush_over_stall", 24'h0, 24'h0, 4'h0, 5'b00000, 4'b0000);
        bus.flushM = 1'b0;
        bus.stallM = 1'b0;
        set_op(24'h000002, 24'h000003, 24'h0, 1'b0, 2'b00, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("bubble_gate", 24'h000005, 24'h000003, 4'hA, 5'b00100, 4'b0000);

`ifdef EXEC_FWD_EN
        set_op(24'h0000FF, 24'h000001, 24'h0, 1'b0, 2'b00, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fwd_producer", 24'h000100, 24'h000001, 4'h2, 5'b10001, 4'b0000);
        bus.RA1E = 4'h2;
        bus.RA2E = 4'h2;
        set_op(24'h000000, 24'h000000, 24'h0, 1'b0, 2'b00, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fwd_mem_ab", 24'h000200, 24'h000100, 4'h3, 5'b00001, 4'b0000);
        bus.RA1E = 4'h4;
        bus.RA2E = 4'hF;
        bus.regWriteW = 1'b1;
        bus.WA3W      = 4'h4;
        bus.ResultW   = 24'h0000AA;
        set_op(24'h000000, 24'h000000, 24'h0, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fwd_wb", 24'h0000AA, 24'h000000, 4'hF, 5'b10001, 4'b0000);
        bus.RA1E    = 4'hF;
        bus.WA3W    = 4'hF;
        bus.ResultW = 24'h000055;
        set_op(24'h000007, 24'h000000, 24'h0, 1'b0, 2'b00, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fwd_r15_never", 24'h000007, 24'h000000, 4'h6, 5'b10001, 4'b0000);
        bus.RA1E    = 4'h6;
        bus.WA3W    = 4'h6;
        bus.ResultW = 24'h000999;
        set_op(24'h000000, 24'h000000, 24'h0, 1'b0, 2'b00, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fwd_mem_over_wb", 24'h000007, 24'h000000, 4'h1, 5'b00001, 4'b0000);
        bus.regWriteW = 1'b0;
        bus.RA1E      = 4'hF;
`endif

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Execute stage plus EX/MEM pipeline register of the 24-bit pipelined core. Consumes the ID/EX register outputs (operands, immediate, destination, control bits). Computes the ALU result and NZCV flags. Registers the result with pass-through control into the memory stage, with stall/flush control and, optionally, operand forwarding from MEM and WB.

## Interface
Parameters:
- DW, 24, datapath width
- RW, 4, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- SrcA, SrcB  in  DW  register operands from ID/EX
- ExtImm  in  DW  extended immediate
- WA3E  in  RW  destination register
- regWriteE, aluSrcE, PCSrcE, memToRegE, memWriteE  in  1  control from ID/EX
- aluControlE  in  2  ALU operation
- validE  in  1  ID/EX slot holds a real instruction
- stallM  in  1  hold EX/MEM contents
- flushM  in  1  insert bubble into EX/MEM
- RA1E, RA2E  in  RW  source registers (forwarding only)
- ResultW  in  DW; WA3W  in  RW; regWriteW  in  1  writeback bus (forwarding only)
- ALUResultM, WriteDataM  out  DW  registered result / store data
- WA3M  out  RW; regWriteM, PCSrcM, memToRegM, memWriteM, validM  out  1  registered control
- FlagsM  out  4  registered NZCV, bit 3 = N

## Operation
- Operand B = aluSrcE ? ExtImm : (forwarded) SrcB. WriteDataM captures the forwarded SrcB, never ExtImm.
- aluControlE: 00 ADD, 01 SUB (A−B), 10 AND, 11 OR. Result truncated to DW bits.
- N = result[DW−1]. Z = (result == 0).
- ADD: C = carry-out of bit DW−1; V = signed overflow.
- SUB: C = NOT borrow (A ≥ B unsigned → 1); V = signed overflow.
- AND/OR: C = 0, V = 0.
- EX/MEM update priority per edge: reset > flushM > stallM > load.
  - reset or flushM: all outputs 0, including validM and FlagsM.
  - stallM: every output holds.
  - load: ALU result, flags, WriteData, WA3E and controls are captured; validM = validE.
- Gating: when validE = 0 on load, regWriteM, memWriteM and PCSrcM are forced 0. Data fields are still captured.

## Timing
- Latency 1 cycle, E inputs → M outputs. No combinational path from inputs to outputs.
- Reset value of every output is 0.
- flushM and stallM asserted together: flush wins.
- Stall is held for N cycles: outputs are identical for N+1 edges, counting from the load edge.
- Forwarding selects are combinational within the cycle. Their result is visible at M on the next edge.

## Configuration
- EXEC_FWD_EN defined: forwarding logic is compiled in. Per source A/B:
  - MEM hit when validM & regWriteM & WA3M == RAxE & RAxE != 4'hF → use ALUResultM.
  - Otherwise, WB hit when regWriteW & WA3W == RAxE & RAxE != 4'hF → use ResultW.
  - Otherwise use SrcA/SrcB.
  - MEM takes priority over WB.
- EXEC_FWD_EN undefined: SrcA/SrcB are used directly. RA1E, RA2E, ResultW, WA3W and regWriteW are present but ignored.

## Structure
- Shared package exec_pkg:
  - DW/RW constants
  - alu_op_t enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
  - flag bit indices FLAG_N/Z/C/V
  - fwd_sel_t enum (FWD_NONE, FWD_MEM, FWD_WB)
- One combinational sub-module, alu24: inputs a, b, op; outputs y and nzcv. The register, forwarding and gating logic live in execute_stage.

## Test plan
- Reset: drive reset 2 cycles with nonzero inputs → all outputs 0. First load edge after release captures inputs.
- ADD overflow: A=0x7FFFFF, B=0x000001, op 00, validE=1 → ALUResultM=0x800000, FlagsM=N1 Z0 C0 V1 (4'b1001).
- SUB: A=0x000005, B=0x000005, op 01 → result 0 with NZCV=0110. A=0x000000, B=0x000001 → 0xFFFFFF with NZCV=1000.
- Immediate and store data: aluSrcE=1, SrcB=0x123456, ExtImm=0x000010, A=0x000001, ADD, memWriteE=1 → ALUResultM=0x000011, WriteDataM=0x123456, memWriteM=1.
- Stall then flush:
  - load op, then stallM 3 cycles → outputs stable for 3 edges;
  - then flushM+stallM together → validM=0, regWriteM=0, ALUResultM=0;
  - then validE=0 with regWriteE=1 → regWriteM=0.
- (EXEC_FWD_EN) Back-to-back dependency:
  - instr1 writes R2 = 0x000100;
  - instr2 has RA1E=2, stale SrcA=0 → uses 0x000100;
  - WB-only hit with ResultW=0x0000AA uses 0x0000AA;
  - RA1E=15 never forwards.
